mgmt_phy_target: RTL and testbench



---
 rtl/mgmt_phy_target.sv | 203 ++++++++++++++++++++
 tb/tb_mgmt_phy_target.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mgmt_phy_target.sv
// LTPI Target-side PHY management FSM: detect, speed, advertise, accept and operational phases.
// Optional macro MGMT_PHY_TARGET_ACCEPT_TIMEOUT_EN adds a 1 ms timeout to CONFIGURATION_OR_ACCEPT.
package mgmt_phy_target_pkg;

  localparam int         TIMER_1MS_60MHZ = 60000;
  localparam logic [3:0] frame_length    = 4'd15;

  typedef enum logic [3:0] {
    ST_INIT                        = 4'd0,
    ST_COMMA_HUNTING               = 4'd1,
    ST_WAIT_LINK_DETECT_LOCKED     = 4'd2,
    ST_WAIT_LINK_SPEED_LOCKED      = 4'd3,
    ST_LINK_SPEED_CHANGE           = 4'd4,
    ST_WAIT_LINK_ADVERTISE_LOCKED  = 4'd5,
    ST_CONFIGURATION_OR_ACCEPT     = 4'd6,
    ST_OPERATIONAL                 = 4'd7,
    ST_OPERATIONAL_RESET           = 4'd8,
    ST_LINK_LOST_ERR               = 4'd9
  } rstate_t;

  typedef rstate_t link_state_t;

  typedef struct packed {
    logic software_reset;
    logic retraining_request;
  } LTPI_CSR_In_t;

endpackage

module mgmt_phy_target
  import mgmt_phy_target_pkg::*;
#(
  parameter int TIMER_1MS_CYCLES = TIMER_1MS_60MHZ,
  parameter int ACCEPT_FRM_NUM   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   tx_frm_offset,
  input  logic         aligned,
  input  logic         frame_crc_err,
  input  logic         link_detect_locked,
  input  logic         transmited_255_detect_frm,
  input  logic         speed_locked,
  input  logic         link_speed_timeout_detect,
  input  logic         advertise_locked,
  input  logic         configure_frm_rcv,
  input  logic         crc_consec_loss,
  input  logic         unexpected_frame_error,
  input  logic         operational_frm_lost_error,
  input  logic         remote_software_reset,
  input  link_state_t  remote_link_state,
  input  logic         pll_configuration_done,
  input  logic         change_freq_st,
  input  LTPI_CSR_In_t LTPI_CSR_In,
  output logic         pll_reconfig,
  output rstate_t      LTPI_link_ST
);

  localparam logic [15:0] TIMER_LAST  = 16'(TIMER_1MS_CYCLES - 1);
  localparam logic [3:0]  ACCEPT_LAST = 4'(ACCEPT_FRM_NUM);

  rstate_t     r_state;
  rstate_t     w_stateNext;
  logic        r_pllReconfig;
  logic [15:0] r_timer;
  logic        r_timerDone;
  logic [3:0]  r_acceptCnt;

  logic        w_frameEnd;
  logic        w_linkErr;
  logic [3:0]  w_acceptInc;
  logic        w_acceptDone;
  logic        w_timedState;
  logic        w_timerRun;
  logic        w_unused;

  assign w_frameEnd   = (tx_frm_offset == frame_length);
  assign w_linkErr    = crc_consec_loss | (unexpected_frame_error & ~frame_crc_err);
  assign w_acceptInc  = r_acceptCnt + 4'd1;
  assign w_acceptDone = w_frameEnd && (w_acceptInc == ACCEPT_LAST);
  assign w_unused     = ^remote_link_state;

`ifdef MGMT_PHY_TARGET_ACCEPT_TIMEOUT_EN
  assign w_timedState = (r_state == ST_COMMA_HUNTING) ||
                        (r_state == ST_WAIT_LINK_ADVERTISE_LOCKED) ||
                        (r_state == ST_CONFIGURATION_OR_ACCEPT);
`else
  assign w_timedState = (r_state == ST_COMMA_HUNTING) ||
                        (r_state == ST_WAIT_LINK_ADVERTISE_LOCKED);
`endif

  // The timer restarts on every state change so each timed phase gets a full 1 ms.
  assign w_timerRun = w_timedState && (w_stateNext == r_state);

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_INIT: begin
        if (pll_configuration_done) w_stateNext = ST_COMMA_HUNTING;
      end
      ST_COMMA_HUNTING: begin
        if (aligned)
          w_stateNext = change_freq_st ? ST_WAIT_LINK_ADVERTISE_LOCKED : ST_WAIT_LINK_DETECT_LOCKED;
        else if (change_freq_st && r_timerDone)
          w_stateNext = ST_LINK_LOST_ERR;
      end
      ST_WAIT_LINK_DETECT_LOCKED: begin
        if (w_linkErr)
          w_stateNext = ST_LINK_LOST_ERR;
        else if (link_detect_locked && transmited_255_detect_frm && w_frameEnd)
          w_stateNext = ST_WAIT_LINK_SPEED_LOCKED;
      end
      ST_WAIT_LINK_SPEED_LOCKED: begin
        if (w_linkErr || link_speed_timeout_detect)
          w_stateNext = ST_LINK_LOST_ERR;
        else if (speed_locked && w_frameEnd)
          w_stateNext = ST_LINK_SPEED_CHANGE;
      end
      ST_LINK_SPEED_CHANGE: begin
        w_stateNext = ST_LINK_SPEED_CHANGE;
      end
      ST_WAIT_LINK_ADVERTISE_LOCKED: begin
        if (w_linkErr)
          w_stateNext = ST_LINK_LOST_ERR;
        else if (configure_frm_rcv && advertise_locked && w_frameEnd)
          w_stateNext = ST_CONFIGURATION_OR_ACCEPT;
        else if (r_timerDone && !advertise_locked)
          w_stateNext = ST_LINK_LOST_ERR;
      end
      ST_CONFIGURATION_OR_ACCEPT: begin
        if (w_linkErr)
          w_stateNext = ST_LINK_LOST_ERR;
        else if (w_acceptDone)
          w_stateNext = ST_OPERATIONAL;
`ifdef MGMT_PHY_TARGET_ACCEPT_TIMEOUT_EN
        else if (r_timerDone && w_frameEnd)
          w_stateNext = ST_WAIT_LINK_ADVERTISE_LOCKED;
`endif
      end
      ST_OPERATIONAL: begin
        if (w_linkErr)
          w_stateNext = ST_LINK_LOST_ERR;
        else if (LTPI_CSR_In.software_reset || remote_software_reset)
          w_stateNext = ST_OPERATIONAL_RESET;
        else if (LTPI_CSR_In.retraining_request)
          w_stateNext = ST_INIT;
        else if (operational_frm_lost_error)
          w_stateNext = ST_LINK_LOST_ERR;
      end
      ST_OPERATIONAL_RESET: begin
        if (w_linkErr)
          w_stateNext = ST_LINK_LOST_ERR;
        else if (w_frameEnd)
          w_stateNext = ST_WAIT_LINK_ADVERTISE_LOCKED;
      end
      ST_LINK_LOST_ERR: begin
        w_stateNext = ST_INIT;
      end
      default: begin
        w_stateNext = ST_INIT;
      end
    endcase
  end

  // PLL request follows the state being entered, so it lands in the same cycle as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_INIT;
      r_pllReconfig <= 1'b0;
    end else begin
      r_state       <= w_stateNext;
      r_pllReconfig <= (w_stateNext == ST_INIT) || (w_stateNext == ST_LINK_SPEED_CHANGE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer     <= 16'd0;
      r_timerDone <= 1'b0;
    end else if (!w_timerRun) begin
      r_timer     <= 16'd0;
      r_timerDone <= 1'b0;
    end else if (r_timer == TIMER_LAST) begin
      r_timerDone <= 1'b1;
    end else begin
      r_timer <= r_timer + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acceptCnt <= 4'd0;
    end else if (r_state != ST_CONFIGURATION_OR_ACCEPT) begin
      r_acceptCnt <= 4'd0;
    end else if (w_frameEnd) begin
      r_acceptCnt <= w_acceptInc;
    end
  end

  assign pll_reconfig = r_pllReconfig;
  assign LTPI_link_ST = r_state;

endmodule

// File: tb/tb_mgmt_phy_target.sv
// Scoreboard bench for mgmt_phy_target: scenarios push expected (state, pll_reconfig, cycle)
// events into a queue and an independent monitor pops them whenever the DUT outputs change.
module tb_mgmt_phy_target;
  import mgmt_phy_target_pkg::*;

  localparam int         TIMER_CYC  = 100;
  localparam int         ACCEPT_NUM = 4;
  localparam logic [3:0] FRAME_END  = 4'd15;

  typedef struct {
    rstate_t     st;
    logic        pll;
    int unsigned cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   tx_frm_offset;
  logic         aligned;
  logic         frame_crc_err;
  logic         link_detect_locked;
  logic         transmited_255_detect_frm;
  logic         speed_locked;
  logic         link_speed_timeout_detect;
  logic         advertise_locked;
  logic         configure_frm_rcv;
  logic         crc_consec_loss;
  logic         unexpected_frame_error;
  logic         operational_frm_lost_error;
  logic         remote_software_reset;
  link_state_t  remote_link_state;
  logic         pll_configuration_done;
  logic         change_freq_st;
  LTPI_CSR_In_t csrIn;
  logic         pll_reconfig;
  rstate_t      LTPI_link_ST;

  int unsigned  cyc = 0;
  int           nChecks = 0;
  int           nFail = 0;
  int           frameMode = 0;
  bit           noiseEn = 1'b0;
  int unsigned  commaEntry = 0;
  exp_t         expQ[$];
  rstate_t      prevSt = ST_INIT;
  logic         prevPll = 1'b0;

  mgmt_phy_target #(
    .TIMER_1MS_CYCLES(TIMER_CYC),
    .ACCEPT_FRM_NUM(ACCEPT_NUM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_frm_offset(tx_frm_offset),
    .aligned(aligned),
    .frame_crc_err(frame_crc_err),
    .link_detect_locked(link_detect_locked),
    .transmited_255_detect_frm(transmited_255_detect_frm),
    .speed_locked(speed_locked),
    .link_speed_timeout_detect(link_speed_timeout_detect),
    .advertise_locked(advertise_locked),
    .configure_frm_rcv(configure_frm_rcv),
    .crc_consec_loss(crc_consec_loss),
    .unexpected_frame_error(unexpected_frame_error),
    .operational_frm_lost_error(operational_frm_lost_error),
    .remote_software_reset(remote_software_reset),
    .remote_link_state(remote_link_state),
    .pll_configuration_done(pll_configuration_done),
    .change_freq_st(change_freq_st),
    .LTPI_CSR_In(csrIn),
    .pll_reconfig(pll_reconfig),
    .LTPI_link_ST(LTPI_link_ST)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any change of state or pll_reconfig is an event that must match the queue head.
  always @(negedge clk) begin
    if (reset) begin
      prevSt  = ST_INIT;
      prevPll = 1'b0;
    end else if (LTPI_link_ST !== prevSt || pll_reconfig !== prevPll) begin
      nChecks++;
      if (expQ.size() == 0) begin
        nFail++;
        $display("[TB] FAIL unexpectedEvent: got state=%s pll=%0b at cycle %0d, no event expected",
                 LTPI_link_ST.name(), pll_reconfig, cyc);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if (LTPI_link_ST !== e.st || pll_reconfig !== e.pll || cyc != e.cyc) begin
          nFail++;
          $display("[TB] FAIL transition: got state=%s pll=%0b cycle=%0d, expected state=%s pll=%0b cycle=%0d",
                   LTPI_link_ST.name(), pll_reconfig, cyc, e.st.name(), e.pll, e.cyc);
        end
      end
      prevSt  = LTPI_link_ST;
      prevPll = pll_reconfig;
    end
  end

  task automatic expectAbs(input rstate_t s, input logic p, input int unsigned atCyc);
    exp_t e;
    e.st  = s;
    e.pll = p;
    e.cyc = atCyc;
    expQ.push_back(e);
  endtask

  task automatic expectAt(input rstate_t s, input logic p, input int unsigned dc);
    expectAbs(s, p, cyc + dc);
  endtask

  task automatic checkOutput(input string name, input rstate_t expSt, input logic expPll);
    nChecks++;
    if (LTPI_link_ST !== expSt || pll_reconfig !== expPll) begin
      nFail++;
      $display("[TB] FAIL %s: got state=%s pll=%0b, expected state=%s pll=%0b",
               name, LTPI_link_ST.name(), pll_reconfig, expSt.name(), expPll);
    end
  endtask

  // One clock of stimulus: frame offset per mode, plus CRC-masked noise on unexpected_frame_error.
  task automatic applyStimulus();
    int r;
    @(negedge clk);
    case (frameMode)
      1:       tx_frm_offset = (tx_frm_offset == FRAME_END) ? 4'd0 : tx_frm_offset + 4'd1;
      2:       tx_frm_offset = ($urandom_range(0, 3) == 0) ? FRAME_END : 4'($urandom_range(0, 14));
      default: tx_frm_offset = 4'd0;
    endcase
    if (noiseEn) begin
      r = int'($urandom_range(0, 3));
      unexpected_frame_error = (r == 0);
      frame_crc_err          = (r <= 1);
    end else begin
      unexpected_frame_error = 1'b0;
      frame_crc_err          = 1'b0;
    end
  endtask

  task automatic clearInputs();
    tx_frm_offset              = 4'd0;
    aligned                    = 1'b0;
    frame_crc_err              = 1'b0;
    link_detect_locked         = 1'b0;
    transmited_255_detect_frm  = 1'b0;
    speed_locked               = 1'b0;
    link_speed_timeout_detect  = 1'b0;
    advertise_locked           = 1'b0;
    configure_frm_rcv          = 1'b0;
    crc_consec_loss            = 1'b0;
    unexpected_frame_error     = 1'b0;
    operational_frm_lost_error = 1'b0;
    remote_software_reset      = 1'b0;
    remote_link_state          = ST_OPERATIONAL;
    pll_configuration_done     = 1'b0;
    change_freq_st             = 1'b0;
    csrIn                      = '0;
    frameMode                  = 0;
    noiseEn                    = 1'b0;
  endtask

  task automatic waitDrain(input int maxC);
    for (int i = 0; i < maxC; i++) begin
      if (expQ.size() == 0) return;
      applyStimulus();
    end
    if (expQ.size() != 0) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL drainTimeout: %0d expected events still pending at cycle %0d, required 0",
               expQ.size(), cyc);
    end
  endtask

  // Conditions are set at the current negedge; the first qualifying frame end fires the transition.
  task automatic runToFrameEnd(input rstate_t s, input logic p, input int maxC);
    for (int i = 0; i < maxC; i++) begin
      if (tx_frm_offset == FRAME_END) begin
        expectAt(s, p, 1);
        return;
      end
      applyStimulus();
    end
    nChecks++;
    nFail++;
    $display("[TB] FAIL frameEndBound: no frame end within %0d cycles, required one", maxC);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("asyncReset", ST_INIT, 1'b0);
    clearInputs();
    expQ.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expectAt(ST_INIT, 1'b1, 1);
  endtask

  task automatic toComma();
    repeat ($urandom_range(1, 4)) applyStimulus();
    pll_configuration_done = 1'b1;
    expectAt(ST_COMMA_HUNTING, 1'b0, 1);
    commaEntry = cyc + 1;
    applyStimulus();
    pll_configuration_done = 1'b0;
  endtask

  task automatic countAcceptFrames();
    int n = 0;
    for (int i = 0; i < 200 && n < ACCEPT_NUM; i++) begin
      applyStimulus();
      if (tx_frm_offset == FRAME_END) begin
        n++;
        if (n == ACCEPT_NUM) expectAt(ST_OPERATIONAL, 1'b0, 1);
      end
    end
  endtask

  task automatic basePath(input bit speedTimeout);
    doReset();
    toComma();
    frameMode = 1;
    noiseEn   = 1'b1;
    repeat ($urandom_range(0, 20)) applyStimulus();
    aligned = 1'b1;
    expectAt(ST_WAIT_LINK_DETECT_LOCKED, 1'b0, 1);
    applyStimulus();
    link_detect_locked = 1'b1;
    repeat ($urandom_range(20, 40)) applyStimulus();
    transmited_255_detect_frm = 1'b1;
    runToFrameEnd(ST_WAIT_LINK_SPEED_LOCKED, 1'b0, 40);
    applyStimulus();
    repeat ($urandom_range(0, 20)) applyStimulus();
    if (speedTimeout) begin
      link_speed_timeout_detect = 1'b1;
      expectAt(ST_LINK_LOST_ERR, 1'b0, 1);
      expectAt(ST_INIT, 1'b1, 2);
      applyStimulus();
      link_speed_timeout_detect = 1'b0;
    end else begin
      speed_locked = 1'b1;
      runToFrameEnd(ST_LINK_SPEED_CHANGE, 1'b1, 40);
      repeat (30) applyStimulus();
    end
    waitDrain(20);
  endtask

  task automatic commaTimeout();
    doReset();
    change_freq_st = 1'b1;
    toComma();
    noiseEn = 1'b1;
    expectAbs(ST_LINK_LOST_ERR, 1'b0, commaEntry + TIMER_CYC + 1);
    expectAbs(ST_INIT, 1'b1, commaEntry + TIMER_CYC + 2);
    waitDrain(TIMER_CYC + 20);
  endtask

  task automatic advTimeout();
    doReset();
    change_freq_st = 1'b1;
    toComma();
    frameMode = 2;
    noiseEn   = 1'b1;
    repeat ($urandom_range(0, 30)) applyStimulus();
    aligned = 1'b1;
    expectAt(ST_WAIT_LINK_ADVERTISE_LOCKED, 1'b0, 1);
    expectAt(ST_LINK_LOST_ERR, 1'b0, TIMER_CYC + 2);
    expectAt(ST_INIT, 1'b1, TIMER_CYC + 3);
    waitDrain(TIMER_CYC + 20);
  endtask

  task automatic bringUp(input bit stopAtAccept);
    doReset();
    toComma();
    change_freq_st = 1'b1;
    frameMode      = 2;
    noiseEn        = 1'b1;
    repeat ($urandom_range(0, 40)) applyStimulus();
    aligned = 1'b1;
    expectAt(ST_WAIT_LINK_ADVERTISE_LOCKED, 1'b0, 1);
    applyStimulus();
    repeat ($urandom_range(0, 30)) applyStimulus();
    advertise_locked = 1'b1;
    repeat ($urandom_range(0, 150)) applyStimulus();
    configure_frm_rcv = 1'b1;
    runToFrameEnd(ST_CONFIGURATION_OR_ACCEPT, 1'b0, 200);
    frameMode = 1;
    if (stopAtAccept) return;
    countAcceptFrames();
    applyStimulus();
    configure_frm_rcv = 1'b0;
    waitDrain(20);
  endtask

  task automatic acceptStall();
    bringUp(1'b1);
    frameMode = 0;
    repeat (150) applyStimulus();
`ifdef MGMT_PHY_TARGET_ACCEPT_TIMEOUT_EN
    applyStimulus();
    tx_frm_offset = FRAME_END;
    runToFrameEnd(ST_WAIT_LINK_ADVERTISE_LOCKED, 1'b0, 1);
`else
    frameMode = 1;
    countAcceptFrames();
`endif
    applyStimulus();
    waitDrain(20);
  endtask

  task automatic opExit(input int kind);
    noiseEn = 1'b0;
    applyStimulus();
    case (kind)
      0: begin
        crc_consec_loss       = 1'b1;
        remote_software_reset = 1'b1;
        expectAt(ST_LINK_LOST_ERR, 1'b0, 1);
        expectAt(ST_INIT, 1'b1, 2);
      end
      1: begin
        unexpected_frame_error   = 1'b1;
        csrIn.retraining_request = 1'b1;
        expectAt(ST_LINK_LOST_ERR, 1'b0, 1);
        expectAt(ST_INIT, 1'b1, 2);
      end
      2: begin
        remote_software_reset = 1'b1;
        expectAt(ST_OPERATIONAL_RESET, 1'b0, 1);
      end
      3: begin
        csrIn.software_reset       = 1'b1;
        csrIn.retraining_request   = 1'b1;
        operational_frm_lost_error = 1'b1;
        expectAt(ST_OPERATIONAL_RESET, 1'b0, 1);
      end
      4: begin
        csrIn.retraining_request   = 1'b1;
        operational_frm_lost_error = 1'b1;
        expectAt(ST_INIT, 1'b1, 1);
      end
      default: begin
        operational_frm_lost_error = 1'b1;
        expectAt(ST_LINK_LOST_ERR, 1'b0, 1);
        expectAt(ST_INIT, 1'b1, 2);
      end
    endcase
    applyStimulus();
    crc_consec_loss            = 1'b0;
    remote_software_reset      = 1'b0;
    operational_frm_lost_error = 1'b0;
    csrIn                      = '0;
    if (kind == 2 || kind == 3) runToFrameEnd(ST_WAIT_LINK_ADVERTISE_LOCKED, 1'b0, 64);
    waitDrain(20);
  endtask

  initial begin
    clearInputs();
    repeat (2) @(negedge clk);
    basePath(1'b0);
    basePath(1'b1);
    commaTimeout();
    advTimeout();
    acceptStall();
    for (int k = 0; k < 6; k++) begin
      bringUp(1'b0);
      opExit(k);
    end
    for (int k = 0; k < 2; k++) begin
      bringUp(1'b0);
      opExit(int'($urandom_range(0, 5)));
    end
    waitDrain(50);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #500000;
    nFail++;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d, required test completion", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
